// File: rtl/rom_msg_streamer_if.sv
// ROM read port plus UART TX valid/ready channel used by rom_msg_streamer.
// master: the streamer (drives ROM address and TX byte).
// slave: the ROM / UART TX side.
interface rom_msg_streamer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rom_addr,
        input  rom_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/rom_msg_streamer.sv
// Walks message ROM addresses 0..MSG_LEN-1 on a start pulse and hands each
// byte to the UART transmitter over valid/ready. Every byte costs three
// states (READ, LATCH, SEND) because the ROM has one cycle of read latency.
// Optional: define STREAMER_CRLF_EN to append 0x0D, 0x0A after the message.
module rom_msg_streamer #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int MSG_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    rom_msg_streamer_if.master bus,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_FINISH
`ifdef STREAMER_CRLF_EN
        ,
        S_CR,
        S_LF
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs;

    assign hs = tx_valid_q && bus.tx_ready;

    // Next-state and next-output logic; all outputs come straight from flops.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start is only looked at here, so pulses while busy or
                // during the FINISH/done cycle are dropped, not queued.
                if (start) begin
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                // ROM captures rom_addr at the end of this cycle.
                state_d = S_LATCH;
            end
            S_LATCH: begin
                tx_data_d  = bus.rom_data;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    if (rom_addr_q == LAST_ADDR) begin
`ifdef STREAMER_CRLF_EN
                        state_d = S_CR;
`else
                        // done/busy are set on entry so the pulse lands in
                        // the cycle right after the final handshake.
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = S_READ;
                    end
                end
            end
`ifdef STREAMER_CRLF_EN
            S_CR: begin
                // First cycle in the state is the gap (valid low) where the
                // constant is loaded; then wait for the handshake.
                if (!tx_valid_q) begin
                    tx_data_d  = DATA_W'(8'h0D);
                    tx_valid_d = 1'b1;
                end else if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_LF;
                end
            end
            S_LF: begin
                if (!tx_valid_q) begin
                    tx_data_d  = DATA_W'(8'h0A);
                    tx_valid_d = 1'b1;
                end else if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_FINISH;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end
            end
`endif
            S_FINISH: begin
                // done drops via its default; one cycle here swallows start.
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer with no done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rom_msg_streamer.sv
// Bench for rom_msg_streamer: an 8-byte instance and a 1-byte instance share
// one ROM image; the expected byte stream and timing come from a message-level
// model (byte list + per-byte cycle gaps), not from the state machine.
module tb_rom_msg_streamer;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic tx_ready = 1'b0;
    logic sel = 1'b0;
    logic busy8, done8, busy1, done1;
    logic [7:0] rom [16];

    int n_chk = 0;
    int n_bad = 0;

    rom_msg_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus8();
    rom_msg_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1();

    rom_msg_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MSG_LEN(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start & ~sel),
        .bus   (bus8),
        .busy  (busy8),
        .done  (done8)
    );

    rom_msg_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MSG_LEN(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start & sel),
        .bus   (bus1),
        .busy  (busy1),
        .done  (done1)
    );

    initial forever #5 clk = ~clk;

    // synchronous ROMs, one cycle read latency
    always @(posedge clk) begin
        bus8.rom_data <= rom[bus8.rom_addr];
        bus1.rom_data <= rom[bus1.rom_addr];
    end
    assign bus8.tx_ready = tx_ready;
    assign bus1.tx_ready = tx_ready;

    logic       o_valid, o_busy, o_done;
    logic [7:0] o_data;
    logic [3:0] o_addr;
    assign o_valid = sel ? bus1.tx_valid : bus8.tx_valid;
    assign o_data  = sel ? bus1.tx_data  : bus8.tx_data;
    assign o_addr  = sel ? bus1.rom_addr : bus8.rom_addr;
    assign o_busy  = sel ? busy1 : busy8;
    assign o_done  = sel ? done1 : done8;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 ready always high, 1 stall 5 cycles on byte 3, 2 random ready
    task automatic run_msg(input logic s, input int mode, input bit repulse, input bit do_rst);
        logic [7:0] exp[$];
        int len;
        int nb = 0;
        int since = 0;
        int stall = 0;
        int cyc = 0;
        bit seen = 0;
        logic [7:0] held = '0;
        len = s ? 1 : 8;
        for (int i = 0; i < len; i++) exp.push_back(rom[i]);
`ifdef STREAMER_CRLF_EN
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
`endif
        @(negedge clk);
        sel = s;
        chk("idle_busy", o_busy, 0);
        tx_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        since = 0;
        while (nb < exp.size()) begin
            @(negedge clk);
            start = 1'b0;
            since++;
            cyc++;
            if (cyc > 500) begin
                chk("timeout", nb, exp.size());
                return;
            end
            chk("busy", o_busy, 1);
            chk("done_early", o_done, 0);
            chk("addr_range", o_addr <= 4'(len - 1), 1);
            if (o_valid) begin
                if (!seen) begin
                    // ROM bytes: 3 cycles per byte; CR/LF: 1-cycle gap
                    chk("latency", since, (nb < len) ? 3 : 2);
                    seen = 1;
                    held = o_data;
                    stall = 0;
                    if (repulse && (nb == 1 || nb == 4)) start = 1'b1;
                    if (do_rst && nb == 3) begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_valid", o_valid, 0);
                        chk("rst_busy", o_busy, 0);
                        chk("rst_addr", o_addr, 0);
                        chk("rst_done", o_done, 0);
                        start = 1'b0;
                        @(negedge clk);
                        chk("rst_hold_valid", o_valid, 0);
                        rst_n = 1'b1;
                        return;
                    end
                end else begin
                    chk("hold", o_data, held);
                end
                case (mode)
                    1:       tx_ready = !(nb == 2 && stall < 5);
                    2:       tx_ready = 1'($urandom_range(0, 1));
                    default: tx_ready = 1'b1;
                endcase
                if (tx_ready) begin
                    chk("byte", o_data, exp[nb]);
                    nb++;
                    seen = 0;
                    since = 0;
                end else begin
                    stall++;
                end
            end else begin
                if (seen) chk("valid_dropped", o_valid, 1);
                seen = 0;
                tx_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (mode == 1) chk("stall_len", stall, 0);
        @(negedge clk);
        chk("done", o_done, 1);
        chk("busy_fall", o_busy, 0);
        chk("valid_off", o_valid, 0);
        start = 1'b1;   // must be ignored: same cycle as done
        @(negedge clk);
        start = 1'b0;
        chk("done_once", o_done, 0);
        chk("start_at_done", o_busy, 0);
        if (s) chk("addr_len1", o_addr, 0);
    endtask

    initial begin
        logic [7:0] msg [8];
        msg = '{8'h50, 8'h31, 8'h20, 8'h57, 8'h49, 8'h4E, 8'h53, 8'h21};
        for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? msg[i] : 8'($urandom);
        rst_n = 1'b0;
        #1;
        chk("rst8_valid", bus8.tx_valid, 0);
        chk("rst8_data", bus8.tx_data, 0);
        chk("rst8_addr", bus8.rom_addr, 0);
        chk("rst8_busy", busy8, 0);
        chk("rst8_done", done8, 0);
        chk("rst1_valid", bus1.tx_valid, 0);
        chk("rst1_busy", busy1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", bus8.tx_valid, 0);

        run_msg(1'b0, 0, 1'b0, 1'b0);   // plain message
        run_msg(1'b0, 1, 1'b0, 1'b0);   // stall on byte 3
        run_msg(1'b0, 0, 1'b1, 1'b0);   // start re-pulsed while busy
        run_msg(1'b0, 0, 1'b0, 1'b1);   // reset in SEND of byte 4
        run_msg(1'b0, 0, 1'b0, 1'b0);   // fresh send from 0x50
        run_msg(1'b1, 0, 1'b0, 1'b0);   // MSG_LEN=1 instance
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            run_msg(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b0);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
